// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU select codes, RV32 opcode/funct7 constants and issue bundle type
package alu_pkg;
   typedef enum logic [3:0] {
      SEL_ADD  = 4'h0, SEL_SLL = 4'h1, SEL_SLT = 4'h2, SEL_SLTU = 4'h3,
      SEL_XOR  = 4'h4, SEL_SRL = 4'h5, SEL_OR  = 4'h6, SEL_AND  = 4'h7,
      SEL_SUB  = 4'h8, SEL_NE  = 4'h9, SEL_EQ  = 4'hA, SEL_GE   = 4'hB,
      SEL_GEU  = 4'hC, SEL_SRA = 4'hD
   } alu_sel_e;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] F7_BASE    = 7'b0000000;
   localparam logic [6:0] F7_ALT     = 7'b0100000;
   localparam logic [6:0] F7_MUL     = 7'b0000001;
   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      alu_sel_e    sel;
      logic [4:0]  rd;
      logic        wen;
      logic        branch;
   } issue_t;
endpackage

// File: rtl/regfile_2r1w.sv
// regfile_2r1w: 32x32 register file, two async reads, one sync write, x0 hardwired to zero
// Ports: clk, rst (async active-low), ra1/ra2 -> rd1/rd2 read ports, we/wa/wd write port.
module regfile_2r1w #(
   parameter int NREGS = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  ra1,
   input  logic [4:0]  ra2,
   output logic [31:0] rd1,
   output logic [31:0] rd2,
   input  logic        we,
   input  logic [4:0]  wa,
   input  logic [31:0] wd
);
   logic [31:0] regs_q [NREGS];
   logic [31:0] regs_d [NREGS];
   always_comb begin
      regs_d = regs_q;
      if (we && wa != 5'd0) regs_d[wa] = wd;
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) regs_q <= '{default: '0};
      else      regs_q <= regs_d;
   end
   assign rd1 = (ra1 == 5'd0) ? 32'd0 : regs_q[ra1];
   assign rd2 = (ra2 == 5'd0) ? 32'd0 : regs_q[ra2];
endmodule

// File: rtl/alu_issue.sv
// alu_issue: decodes RV32I ALU/branch instructions, reads operands, registers one issue bundle
// Ports: clk, rst (async active-low); instr_valid/instr/instr_ready intake; wb_en/wb_rd/wb_data
// register write port; issue_valid/issue_ready handshake with issue_a/b/sel/rd/wen/branch bundle;
// illegal pulses one cycle when an unsupported instruction is consumed.
module alu_issue
   import alu_pkg::*;
#(
   parameter int NREGS = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        instr_valid,
   input  logic [31:0] instr,
   output logic        instr_ready,
   input  logic        wb_en,
   input  logic [4:0]  wb_rd,
   input  logic [31:0] wb_data,
   output logic        issue_valid,
   input  logic        issue_ready,
   output logic [31:0] issue_a,
   output logic [31:0] issue_b,
   output logic [3:0]  issue_sel,
   output logic [4:0]  issue_rd,
   output logic        issue_wen,
   output logic        issue_branch,
   output logic        illegal
);
   logic [6:0]  opcode, f7;
   logic [2:0]  f3;
   logic [4:0]  rs1, rs2, rd;
   logic [31:0] rf_a, rf_b, op_a, op_b;
   logic        accept, ok, shift;
   issue_t      dec, bun_d, bun_q;
   logic        valid_d, valid_q, illegal_d, illegal_q;
   assign opcode = instr[6:0];
   assign rd     = instr[11:7];
   assign f3     = instr[14:12];
   assign rs1    = instr[19:15];
   assign rs2    = instr[24:20];
   assign f7     = instr[31:25];
   regfile_2r1w #(.NREGS(NREGS)) u_rf (
      .clk(clk), .rst(rst), .ra1(rs1), .ra2(rs2), .rd1(rf_a), .rd2(rf_b),
      .we(wb_en), .wa(wb_rd), .wd(wb_data)
   );
   // A write landing in the accept cycle is forwarded so the bundle never sees a stale value.
   assign op_a = (wb_en && wb_rd == rs1 && rs1 != 5'd0) ? wb_data : rf_a;
   assign op_b = (wb_en && wb_rd == rs2 && rs2 != 5'd0) ? wb_data : rf_b;
   assign instr_ready = !valid_q || issue_ready;
   assign accept      = instr_valid && instr_ready;
   always_comb begin
      ok         = 1'b0;
      shift      = 1'b0;
      dec        = '0;
      dec.a      = op_a;
      dec.b      = op_b;
      dec.rd     = rd;
      dec.wen    = rd != 5'd0;
      case (opcode)
         OPC_OP: begin
            ok      = f7 == F7_BASE || (f7 == F7_ALT && (f3 == 3'd0 || f3 == 3'd5));
            dec.sel = f7 == F7_ALT ? (f3 == 3'd0 ? SEL_SUB : SEL_SRA) : alu_sel_e'({1'b0, f3});
         end
         OPC_OPIMM: begin
            // Only shifts carry a funct7 field; other immediates use those bits as imm[11:5].
            shift   = f3 == 3'd1 || f3 == 3'd5;
            ok      = !shift || f7 == F7_BASE || (f3 == 3'd5 && f7 == F7_ALT);
            dec.sel = (f3 == 3'd5 && f7 == F7_ALT) ? SEL_SRA : alu_sel_e'({1'b0, f3});
            dec.b   = shift ? {27'd0, instr[24:20]} : {{20{instr[31]}}, instr[31:20]};
         end
         OPC_LUI: begin
            ok      = 1'b1;
            dec.a   = 32'd0;
            dec.b   = {instr[31:12], 12'd0};
            dec.sel = SEL_ADD;
         end
         OPC_BRANCH: begin
            ok         = f3 != 3'd2 && f3 != 3'd3;
            dec.sel    = f3 == 3'd0 ? SEL_EQ : f3 == 3'd1 ? SEL_NE : f3 == 3'd4 ? SEL_SLT :
                         f3 == 3'd5 ? SEL_GE : f3 == 3'd6 ? SEL_SLTU : SEL_GEU;
            dec.wen    = 1'b0;
            dec.branch = 1'b1;
         end
         default: ok = 1'b0;
      endcase
   end
   always_comb begin
      valid_d   = accept ? ok : (valid_q && !issue_ready);
      bun_d     = (accept && ok) ? dec : bun_q;
      illegal_d = accept && !ok;
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q   <= 1'b0;
         illegal_q <= 1'b0;
         bun_q     <= '0;
      end else begin
         valid_q   <= valid_d;
         illegal_q <= illegal_d;
         bun_q     <= bun_d;
      end
   end
   assign issue_valid  = valid_q;
   assign illegal      = illegal_q;
   assign issue_a      = bun_q.a;
   assign issue_b      = bun_q.b;
   assign issue_sel    = bun_q.sel;
   assign issue_rd     = bun_q.rd;
   assign issue_wen    = bun_q.wen;
   assign issue_branch = bun_q.branch;
endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: directed self-checking bench for alu_issue
module tb_alu_issue;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        instr_valid = 1'b0;
   logic [31:0] instr = 32'd0;
   logic        instr_ready;
   logic        wb_en = 1'b0;
   logic [4:0]  wb_rd = 5'd0;
   logic [31:0] wb_data = 32'd0;
   logic        issue_valid;
   logic        issue_ready = 1'b0;
   logic [31:0] issue_a, issue_b;
   logic [3:0]  issue_sel;
   logic [4:0]  issue_rd;
   logic        issue_wen, issue_branch, illegal;
   int checks = 0;
   int errors = 0;
   alu_issue dut (
      .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
      .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .issue_valid(issue_valid),
      .issue_ready(issue_ready), .issue_a(issue_a), .issue_b(issue_b), .issue_sel(issue_sel),
      .issue_rd(issue_rd), .issue_wen(issue_wen), .issue_branch(issue_branch), .illegal(illegal)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   function automatic logic [31:0] r_ins(input logic [6:0] f7, input logic [4:0] s2, input logic [4:0] s1,
                                         input logic [2:0] f3, input logic [4:0] d, input logic [6:0] op);
      return {f7, s2, s1, f3, d, op};
   endfunction
   function automatic logic [31:0] i_ins(input logic [11:0] imm, input logic [4:0] s1, input logic [2:0] f3,
                                         input logic [4:0] d);
      return {imm, s1, f3, d, 7'b0010011};
   endfunction
   function automatic logic [31:0] b_ins(input logic [2:0] f3, input logic [4:0] s1, input logic [4:0] s2);
      return {7'd0, s2, s1, f3, 5'd0, 7'b1100011};
   endfunction
   task automatic chk_bundle(input string tag, input logic [31:0] a, input logic [31:0] b, input logic [3:0] sel,
                             input logic [4:0] d, input logic wen, input logic br);
      chk({tag, "_valid"}, {31'd0, issue_valid}, 32'd1);
      chk({tag, "_a"}, issue_a, a);
      chk({tag, "_b"}, issue_b, b);
      chk({tag, "_sel"}, {28'd0, issue_sel}, {28'd0, sel});
      chk({tag, "_rd"}, {27'd0, issue_rd}, {27'd0, d});
      chk({tag, "_wen"}, {31'd0, issue_wen}, {31'd0, wen});
      chk({tag, "_br"}, {31'd0, issue_branch}, {31'd0, br});
   endtask
   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", {31'd0, issue_valid}, 32'd0);
      chk("rst_illegal", {31'd0, illegal}, 32'd0);
      chk("rst_a", issue_a, 32'd0);
      chk("rst_ready", {31'd0, instr_ready}, 32'd1);
      rst = 1'b1;
      wb_en = 1'b1; wb_rd = 5'd1; wb_data = 32'd5;
      tick();
      wb_rd = 5'd2; wb_data = 32'd3;
      tick();
      wb_en = 1'b0;
      issue_ready = 1'b1;
      instr_valid = 1'b1;
      instr = r_ins(7'b0100000, 5'd2, 5'd1, 3'd0, 5'd3, 7'b0110011);
      tick();
      chk_bundle("sub", 32'd5, 32'd3, 4'h8, 5'd3, 1'b1, 1'b0);
      instr = i_ins(12'hFFF, 5'd0, 3'd0, 5'd4);
      tick();
      chk_bundle("addi", 32'd0, 32'hFFFF_FFFF, 4'h0, 5'd4, 1'b1, 1'b0);
      instr = i_ins({7'b0100000, 5'd31}, 5'd1, 3'd5, 5'd5);
      tick();
      chk_bundle("srai", 32'd5, 32'd31, 4'hD, 5'd5, 1'b1, 1'b0);
      instr = i_ins({7'b0100000, 5'd3}, 5'd1, 3'd1, 5'd5);
      tick();
      chk("slli_bad_illegal", {31'd0, illegal}, 32'd1);
      chk("slli_bad_valid", {31'd0, issue_valid}, 32'd0);
      instr_valid = 1'b0;
      tick();
      chk("illegal_pulse_end", {31'd0, illegal}, 32'd0);
      chk("illegal_no_issue", {31'd0, issue_valid}, 32'd0);
      instr_valid = 1'b1;
      instr = r_ins(7'd0, 5'd2, 5'd1, 3'd0, 5'd7, 7'b0110011);
      tick();
      chk_bundle("add", 32'd5, 32'd3, 4'h0, 5'd7, 1'b1, 1'b0);
      issue_ready = 1'b0;
      instr = r_ins(7'd0, 5'd2, 5'd1, 3'd6, 5'd8, 7'b0110011);
      #1;
      chk("stall_ready0", {31'd0, instr_ready}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_valid", {31'd0, issue_valid}, 32'd1);
         chk("stall_rd", {27'd0, issue_rd}, 32'd7);
         chk("stall_sel", {28'd0, issue_sel}, 32'd0);
         chk("stall_ready", {31'd0, instr_ready}, 32'd0);
      end
      issue_ready = 1'b1;
      #1;
      chk("release_ready", {31'd0, instr_ready}, 32'd1);
      tick();
      chk_bundle("or", 32'd5, 32'd3, 4'h6, 5'd8, 1'b1, 1'b0);
      instr_valid = 1'b0;
      tick();
      chk("drain_valid", {31'd0, issue_valid}, 32'd0);
      wb_en = 1'b1; wb_rd = 5'd6; wb_data = 32'hDEAD_0000;
      instr_valid = 1'b1;
      instr = b_ins(3'd1, 5'd6, 5'd0);
      tick();
      chk_bundle("bne", 32'hDEAD_0000, 32'd0, 4'h9, 5'd0, 1'b0, 1'b1);
      wb_rd = 5'd0; wb_data = 32'h1234;
      instr = r_ins(7'd0, 5'd0, 5'd6, 3'd0, 5'd9, 7'b0110011);
      tick();
      chk_bundle("x6_written", 32'hDEAD_0000, 32'd0, 4'h0, 5'd9, 1'b1, 1'b0);
      wb_en = 1'b0;
      instr = r_ins(7'd0, 5'd0, 5'd0, 3'd0, 5'd10, 7'b0110011);
      tick();
      chk_bundle("x0_zero", 32'd0, 32'd0, 4'h0, 5'd10, 1'b1, 1'b0);
      instr = {20'hABCDE, 5'd12, 7'b0110111};
      tick();
      chk_bundle("lui", 32'd0, 32'hABCD_E000, 4'h0, 5'd12, 1'b1, 1'b0);
      instr = r_ins(7'd0, 5'd2, 5'd1, 3'd0, 5'd0, 7'b0110011);
      tick();
      chk_bundle("add_rd0", 32'd5, 32'd3, 4'h0, 5'd0, 1'b0, 1'b0);
      instr = b_ins(3'd7, 5'd1, 5'd2);
      tick();
      chk_bundle("bgeu", 32'd5, 32'd3, 4'hC, 5'd0, 1'b0, 1'b1);
      instr = r_ins(7'b0000001, 5'd2, 5'd1, 3'd0, 5'd3, 7'b0110011);
      tick();
      chk("mul_illegal", {31'd0, illegal}, 32'd1);
      chk("mul_valid", {31'd0, issue_valid}, 32'd0);
      instr = r_ins(7'd0, 5'd2, 5'd1, 3'd0, 5'd11, 7'b0110011);
      tick();
      chk("pre_rst_valid", {31'd0, issue_valid}, 32'd1);
      issue_ready = 1'b0;
      instr_valid = 1'b0;
      rst = 1'b0;
      #1;
      chk("async_rst_valid", {31'd0, issue_valid}, 32'd0);
      chk("async_rst_a", issue_a, 32'd0);
      tick();
      rst = 1'b1;
      issue_ready = 1'b1;
      instr_valid = 1'b1;
      instr = r_ins(7'd0, 5'd0, 5'd1, 3'd0, 5'd11, 7'b0110011);
      #1;
      chk("post_rst_ready", {31'd0, instr_ready}, 32'd1);
      tick();
      chk_bundle("x1_cleared", 32'd0, 32'd0, 4'h0, 5'd11, 1'b1, 1'b0);
      instr_valid = 1'b0;
      tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
